// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Owns the fetch PC, issues one instruction-memory request at a time over
// req/ack, and buffers returned words in a small FIFO that feeds decode over
// valid/ready. Jump/branch redirects flush the FIFO and retarget fetch. A
// request already in flight is allowed to finish, and its word is dropped.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] pcbranch,
    input  logic [31:0] pcjump
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    req_addr;
    logic [31:0]    instr_mem [DEPTH];
    logic [31:0]    pc_mem    [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           redirect;
    logic [31:0]    target;
    logic           pop;
    logic           push;
    logic [CW-1:0]  count_after_pop;

    assign redirect        = jump | pcsrc;
    assign target          = jump ? pcjump : pcbranch;
    assign pop             = instr_valid & instr_ready;
    assign push            = imem_req & imem_ack & (state == REQ) & ~redirect;
    assign count_after_pop = count - CW'(pop);

    assign imem_addr   = req_addr;
    assign instr_valid = (count != '0);
    assign instr       = instr_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign pcplus4     = instr_pc + 32'd4;

    // Request FSM: issue a fetch when there is room, and wait for ack, including on squashed requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            imem_req <= 1'b0;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (!redirect && (count_after_pop < CW'(DEPTH))) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        req_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Fetch PC: redirects take the word-aligned target; accepted transfers advance by one word.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target & ~32'h3;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Instruction FIFO: a redirect flushes it; otherwise push and pop are independent.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]    <= req_addr;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A main instance (RESET_PC=0) is driven through normal streaming, full-FIFO
// stall, redirects during and alongside requests, and mid-run reset. A second
// instance (RESET_PC=FFFFFFF8) runs alongside it with instant acks to exercise
// address wrap-around.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic        jump;
    logic [31:0] pcbranch;
    logic [31:0] pcjump;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic [31:0] w_pcplus4;

    logic        auto_ack;
    logic        manual_ack;

    int checks   = 0;
    int failures = 0;

    assign imem_ack   = auto_ack ? imem_req : manual_ack;
    assign imem_rdata = imem_addr ^ K;
    assign w_ack      = w_req;
    assign w_rdata    = w_addr ^ K;

    fetch_unit #(.DEPTH(2), .RESET_PC(32'h00000000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pcplus4     (pcplus4),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .pcbranch    (pcbranch),
        .pcjump      (pcjump)
    );

    fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFFFFF8)) dut_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ack    (w_ack),
        .imem_rdata  (w_rdata),
        .instr_valid (w_valid),
        .instr_ready (1'b1),
        .instr       (w_instr),
        .instr_pc    (w_pc),
        .pcplus4     (w_pcplus4),
        .pcsrc       (1'b0),
        .jump        (1'b0),
        .pcbranch    (32'h0),
        .pcjump      (32'h0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic ack, input logic j, input logic b,
                                 input logic [31:0] pb, input logic [31:0] pj);
        instr_ready = rdy;
        manual_ack  = ack;
        jump        = j;
        pcsrc       = b;
        pcbranch    = pb;
        pcjump      = pj;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Directed scenarios in sequence, then the summary line.
    initial begin
        reset      = 1'b1;
        auto_ack   = 1'b1;
        manual_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Streaming with instant ack and ready=1, plus wrap-around on the second instance.
        $display("[TB] streaming and wrap-around");
        applyReset();
        checkOutput("rst_req", imem_req, 32'd0);
        checkOutput("rst_valid", instr_valid, 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_pc", instr_pc, 32'd0);
        checkOutput("rst_wreq", w_req, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("s_req", imem_req, 32'd1);
            checkOutput("s_addr", imem_addr, 32'(4 * i));
            checkOutput("s_gap_valid", instr_valid, 32'd0);
            checkOutput("w_addr", w_addr, 32'hFFFFFFF8 + 32'(4 * i));
            step();
            checkOutput("s_valid", instr_valid, 32'd1);
            checkOutput("s_pc", instr_pc, 32'(4 * i));
            checkOutput("s_instr", instr, 32'(4 * i) ^ K);
            checkOutput("s_pcplus4", pcplus4, 32'(4 * i + 4));
            checkOutput("s_req_idle", imem_req, 32'd0);
            checkOutput("w_valid", w_valid, 32'd1);
            checkOutput("w_pc", w_pc, 32'hFFFFFFF8 + 32'(4 * i));
            checkOutput("w_pcplus4", w_pcplus4, 32'hFFFFFFFC + 32'(4 * i));
        end

        // Full FIFO stall with ready=0, then a single-cycle release.
        $display("[TB] full FIFO stall");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyReset();
        step();
        checkOutput("f_req0", imem_req, 32'd1);
        checkOutput("f_addr0", imem_addr, 32'h0);
        step();
        checkOutput("f_valid", instr_valid, 32'd1);
        step();
        checkOutput("f_req1", imem_req, 32'd1);
        checkOutput("f_addr1", imem_addr, 32'h4);
        step();
        checkOutput("f_req_off", imem_req, 32'd0);
        checkOutput("f_head", instr_pc, 32'h0);
        step();
        checkOutput("f_full_a", imem_req, 32'd0);
        step();
        checkOutput("f_full_b", imem_req, 32'd0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checkOutput("f_rel_req", imem_req, 32'd1);
        checkOutput("f_rel_addr", imem_addr, 32'h8);
        checkOutput("f_rel_head", instr_pc, 32'h4);
        step();
        checkOutput("f_refill_req", imem_req, 32'd0);
        step();
        checkOutput("f_refull_req", imem_req, 32'd0);
        checkOutput("f_refull_head", instr_pc, 32'h4);
        reset = 1'b1;
        step();
        checkOutput("f_rst_valid", instr_valid, 32'd0);
        checkOutput("f_rst_req", imem_req, 32'd0);
        checkOutput("f_rst_pc", instr_pc, 32'd0);
        reset = 1'b0;

        // Jump while a delayed-ack request is pending: request holds, word is dropped.
        $display("[TB] jump during pending request");
        auto_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyReset();
        step();
        checkOutput("j_req0", imem_req, 32'd1);
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        checkOutput("j_valid0", instr_valid, 32'd1);
        checkOutput("j_pc0", instr_pc, 32'h0);
        step();
        checkOutput("j_req4", imem_req, 32'd1);
        checkOutput("j_addr4", imem_addr, 32'h4);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00400020);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("j_drain_req", imem_req, 32'd1);
        checkOutput("j_drain_addr", imem_addr, 32'h4);
        checkOutput("j_drain_valid", instr_valid, 32'd0);
        step();
        checkOutput("j_hold_addr", imem_addr, 32'h4);
        step();
        checkOutput("j_hold_req", imem_req, 32'd1);
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        checkOutput("j_ack_req", imem_req, 32'd0);
        checkOutput("j_dropped", instr_valid, 32'd0);
        step();
        checkOutput("j_new_req", imem_req, 32'd1);
        checkOutput("j_new_addr", imem_addr, 32'h00400020);
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        checkOutput("j_new_valid", instr_valid, 32'd1);
        checkOutput("j_new_pc", instr_pc, 32'h00400020);
        checkOutput("j_new_pcplus4", pcplus4, 32'h00400024);
        checkOutput("j_new_instr", instr, 32'h00400020 ^ K);

        // Jump and branch together on an ack cycle, then a misaligned branch in IDLE.
        $display("[TB] simultaneous redirects");
        auto_ack = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyReset();
        step();
        step();
        checkOutput("r_valid", instr_valid, 32'd1);
        step();
        checkOutput("r_addr4", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("r_flush", instr_valid, 32'd0);
        checkOutput("r_req_off", imem_req, 32'd0);
        step();
        checkOutput("r_req", imem_req, 32'd1);
        checkOutput("r_addr", imem_addr, 32'h200);
        step();
        checkOutput("r_pc", instr_pc, 32'h200);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h107, 32'h0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("b_flush", instr_valid, 32'd0);
        checkOutput("b_no_req", imem_req, 32'd0);
        step();
        checkOutput("b_addr", imem_addr, 32'h104);

        // Reset while draining a squashed request, then a fresh fetch from RESET_PC.
        $display("[TB] reset during drain");
        auto_ack = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyReset();
        step();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h300);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("d_drain_req", imem_req, 32'd1);
        reset = 1'b1;
        step();
        checkOutput("d_rst_req", imem_req, 32'd0);
        checkOutput("d_rst_valid", instr_valid, 32'd0);
        reset = 1'b0;
        step();
        checkOutput("d_fresh_req", imem_req, 32'd1);
        checkOutput("d_fresh_addr", imem_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
